// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: data width, FSM state encodings
// and the oversample divider helper used by the receiver top.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int unsigned os_div(
        input int unsigned clk_freq,
        input int unsigned baud_rate,
        input int unsigned oversample
    );
        int unsigned d;
        d = clk_freq / (baud_rate * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: received byte, event pulses and busy.
// master = uart_rx (drives), slave = consumer (observes).
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] data_out;
    logic                   data_valid;
    logic                   frame_err;
    logic                   parity_err;
    logic                   busy;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        input data_out,
        input data_valid,
        input frame_err,
        input parity_err,
        input busy
    );

endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick divider: one-clk tick every DIV clocks.
// Ports: clk, reset (sync, active-high), clear (hold at 0), tick.
module uart_os_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
// Ports: clk, reset (sync, active-high), rx_line (async, idle
// high), rx_o (uart_rx_if.master: data_out, data_valid,
// frame_err, parity_err, busy).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx_line,
    uart_rx_if.master rx_o
);

    localparam int unsigned DIV =
        os_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam logic [OW-1:0] OS_HALF = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);

    localparam int DW = UART_DATA_W;

    uart_state_e   state;
    logic          rx_m;
    logic          rx_s;
    logic [1:0]    fill;
    logic          armed;
    logic          tick;
    logic [OW-1:0] os_cnt;
    logic [2:0]    bit_cnt;
    logic [DW-1:0] shreg;
    logic [DW-1:0] dout;
    logic          dv;
    logic          fe;

    uart_os_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // fill marks when rx_s carries real line samples again after
    // reset; a start is only taken once the line has been seen
    // high, so a line still low from an abandoned frame is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            rx_m  <= rx_line;
            rx_s  <= rx_m;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & rx_s);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic pe;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            dout    <= '0;
            dv      <= 1'b0;
            fe      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            pe      <= 1'b0;
`endif
        end else begin
            dv <= 1'b0;
            fe <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state   <= START;
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_cnt == OS_HALF) begin
                            os_cnt <= '0;
                            state  <= rx_s ? IDLE : DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt  <= '0;
                            shreg   <= {rx_s, shreg[DW-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt  <= '0;
                            par_bad <= rx_s ^ (^shreg);
                            state   <= STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                                if (par_bad) begin
                                    pe <= 1'b1;
                                end else begin
                                    dout <= shreg;
                                    dv   <= 1'b1;
                                end
`else
                                dout <= shreg;
                                dv   <= 1'b1;
`endif
                            end else begin
                                fe    <= 1'b1;
                                state <= BREAK;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rx_o.data_out   = dout;
    assign rx_o.data_valid = dv;
    assign rx_o.frame_err  = fe;
    assign rx_o.busy       = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_o.parity_err = pe;
`else
    assign rx_o.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1.6 MHz / 10 kbaud / x16.
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx;

    localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_LO = 1515 + BIT;
    localparam int LAT_HI = 1535 + BIT;
`else
    localparam int LAT_LO = 1515;
    localparam int LAT_HI = 1535;
`endif

    logic clk;
    logic reset;
    logic rx_line;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ   (1600000),
        .BAUD_RATE  (10000),
        .OVERSAMPLE (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_line (rx_line),
        .rx_o    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    int cyc     = 0;
    int dv_cnt  = 0;
    int fe_cnt  = 0;
    int pe_cnt  = 0;
    int multi   = 0;
    int wide    = 0;
    int last_dv = 0;
    logic [7:0] dv_log [16];
    logic p_dv = 1'b0;
    logic p_fe = 1'b0;
    logic p_pe = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        p_dv <= bus.data_valid;
        p_fe <= bus.frame_err;
        p_pe <= bus.parity_err;
        if (bus.data_valid) begin
            dv_log[dv_cnt & 15] <= bus.data_out;
            dv_cnt  <= dv_cnt + 1;
            last_dv <= cyc;
        end
        if (bus.frame_err)  fe_cnt <= fe_cnt + 1;
        if (bus.parity_err) pe_cnt <= pe_cnt + 1;
        if (32'(bus.data_valid) + 32'(bus.frame_err)
            + 32'(bus.parity_err) > 1)
            multi <= multi + 1;
        if ((bus.data_valid && p_dv) ||
            (bus.frame_err && p_fe) ||
            (bus.parity_err && p_pe))
            wide <= wide + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_line = b;
        wait_clk(n);
    endtask

    task automatic idle(input int n);
        send_bit(1'b1, n);
    endtask

    // Leaves rx_line at the stop level; caller restores idle.
    task automatic send_frame(input logic [7:0] d,
                              input logic stp,
                              input int stp_len);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, BIT);
`endif
        send_bit(stp, stp_len);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] d,
                                input logic par);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
        send_bit(par, BIT);
        send_bit(1'b1, BIT);
    endtask
`endif

    int t0;
    int lat;

    initial begin
        reset   = 1'b1;
        rx_line = 1'b1;
        wait_clk(5);
        chk("rst_dout", 32'(bus.data_out), 32'h00);
        chk("rst_dv",   32'(bus.data_valid), 32'h0);
        chk("rst_fe",   32'(bus.frame_err), 32'h0);
        chk("rst_pe",   32'(bus.parity_err), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        idle(20);

        // Good frame 0xA5
        t0 = cyc;
        send_frame(8'hA5, 1'b1, BIT);
        idle(20);
        lat = last_dv - t0;
        chk("a5_cnt",  32'(dv_cnt), 32'd1);
        chk("a5_dout", 32'(bus.data_out), 32'hA5);
        chk("a5_lat",
            32'(lat >= LAT_LO && lat <= LAT_HI), 32'd1);
        chk("a5_busy", 32'(bus.busy), 32'h0);

        // 40 clk low glitch is a false start
        send_bit(1'b0, 40);
        idle(60);
        chk("gl_busy", 32'(bus.busy), 32'h0);
        chk("gl_dv",   32'(dv_cnt), 32'd1);
        chk("gl_fe",   32'(fe_cnt), 32'd0);
        idle(100);

        // 0x3C with stop held low 400 clk
        send_frame(8'h3C, 1'b0, 380);
        chk("br_busy_hi", 32'(bus.busy), 32'h1);
        chk("br_fe",      32'(fe_cnt), 32'd1);
        send_bit(1'b0, 20);
        idle(10);
        chk("br_busy_lo", 32'(bus.busy), 32'h0);
        chk("br_dout",    32'(bus.data_out), 32'hA5);
        chk("br_dv",      32'(dv_cnt), 32'd1);
        chk("br_fe1",     32'(fe_cnt), 32'd1);
        idle(100);

        // Back-to-back 0x00 / 0xFF, single stop bits
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        idle(20);
        chk("b2b_cnt", 32'(dv_cnt), 32'd3);
        chk("b2b_d0",  32'(dv_log[1]), 32'h00);
        chk("b2b_d1",  32'(dv_log[2]), 32'hFF);
        chk("b2b_fe",  32'(fe_cnt), 32'd1);
        idle(100);

        // Reset pulse in the middle of data bit 4 of 0x0F
        send_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) send_bit(1'b1, BIT);
        send_bit(1'b0, 80);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        chk("mr_dout", 32'(bus.data_out), 32'h00);
        chk("mr_busy", 32'(bus.busy), 32'h0);
        chk("mr_dv",   32'(bus.data_valid), 32'h0);
        chk("mr_fe",   32'(bus.frame_err), 32'h0);
        send_bit(1'b0, 79 + 3 * BIT);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0, BIT);
`endif
        idle(300);
        chk("mr_quiet_dv", 32'(dv_cnt), 32'd3);
        chk("mr_quiet_fe", 32'(fe_cnt), 32'd1);
        chk("mr_idle",     32'(bus.busy), 32'h0);
        send_frame(8'h5A, 1'b1, BIT);
        idle(20);
        chk("mr_5a_cnt",  32'(dv_cnt), 32'd4);
        chk("mr_5a_dout", 32'(bus.data_out), 32'h5A);
        idle(100);

`ifdef UART_RX_PARITY_EN
        send_frame_p(8'h81, 1'b1);
        idle(20);
        chk("par_bad_pe",   32'(pe_cnt), 32'd1);
        chk("par_bad_dv",   32'(dv_cnt), 32'd4);
        chk("par_bad_dout", 32'(bus.data_out), 32'h5A);
        idle(100);
        send_frame_p(8'h81, 1'b0);
        idle(20);
        chk("par_ok_dv",   32'(dv_cnt), 32'd5);
        chk("par_ok_dout", 32'(bus.data_out), 32'h81);
        chk("par_ok_pe",   32'(pe_cnt), 32'd1);
        chk("par_fe",      32'(fe_cnt), 32'd1);
`else
        chk("no_par_pe", 32'(pe_cnt), 32'd0);
`endif

        chk("one_hot", 32'(multi), 32'd0);
        chk("one_clk", 32'(wide), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bits/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, >= 8.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_line  input  1  asynchronous serial input; idle high.
REQ-007 SHALL have port data_out  output  8  last correctly received byte.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on stop bit sampled low.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch (REQ-029).
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass rx_line through a 2-flop synchronizer (rx_s); both flops reset to 1.
REQ-013 SHALL generate an oversample tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks, integer truncation, DIV >= 1; tick counter restarts at 0 when leaving IDLE.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK (plus PARITY per REQ-029).
REQ-015 IDLE: rx_s==0 -> START, tick counter and sample counter cleared the same cycle.
REQ-016 START: after OVERSAMPLE/2 ticks sample rx_s; 0 -> DATA; 1 -> IDLE (false start, no output pulse).
REQ-017 DATA: sample rx_s every OVERSAMPLE ticks, shift LSB first into an 8-bit shift register; after the 8th sample -> STOP.
REQ-018 STOP: after OVERSAMPLE ticks sample rx_s; 1 -> load data_out, pulse data_valid, -> IDLE; 0 -> pulse frame_err, data_out unchanged, -> BREAK.
REQ-019 BREAK: remain until rx_s==1, then -> IDLE; a continuously low line SHALL NOT produce further frames or pulses.
REQ-020 data_valid, frame_err, parity_err SHALL each be high for exactly one clk per event and never simultaneously.
REQ-021 A new start bit SHALL be accepted in the cycle after returning to IDLE (back-to-back frames with one stop bit).
REQ-022 data_out SHALL hold its value between valid frames.

Reset
REQ-023 reset SHALL force state IDLE, data_out=0x00, data_valid=0, frame_err=0, parity_err=0, busy=0, all counters and shift register 0, synchronizer flops 1.
REQ-024 reset asserted mid-frame SHALL abandon the frame without any pulse; reception resumes on the next falling edge after reset deasserts.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL select the parity feature.
REQ-026 Without it: frame is start + 8 data + stop; parity_err tied to 0.
REQ-027 With it: frame is start + 8 data + 1 even-parity bit + stop.
REQ-028 With it: state PARITY is inserted between DATA and STOP, sampled OVERSAMPLE ticks after the last data sample.
REQ-029 With it: parity mismatch with a good stop bit pulses parity_err instead of data_valid, data_out unchanged; a bad stop bit gives frame_err only.

Structure
REQ-030 SHALL place FSM state encodings and UART_DATA_W=8 in shared package uart_pkg.
REQ-031 SHALL implement the tick divider as sub-module uart_os_tick (ports clk, reset, clear, tick).

Verification (CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
REQ-032 Frame 0xA5, good stop -> data_out=0xA5, data_valid one pulse within 1515..1535 clk of the falling edge, busy low afterwards.
REQ-033 Low glitch of 40 clk -> no pulse on any output, busy back to 0 within 100 clk.
REQ-034 Frame 0x3C with stop held low 400 clk, data_out previously 0xA5 -> one frame_err pulse, data_out=0xA5, busy high until line returns high.
REQ-035 0x00 then 0xFF back-to-back, single stop bit each -> two data_valid pulses with 0x00, 0xFF.
REQ-036 reset for 1 clk during data bit 4 -> all outputs at reset values, no pulse; next frame 0x5A -> data_valid, data_out=0x5A.
REQ-037 UART_RX_PARITY_EN defined, 0x81 with parity bit 1 -> parity_err pulse, no data_valid; 0x81 with parity bit 0 -> data_valid, data_out=0x81.
